// File: rtl/song_pkg.sv
// Shared types and pitch helpers for the song player: state encoding,
// note-code frequency table and the half-period calculation.
package song_pkg;

    localparam int unsigned NOTE_W    = 4;
    localparam int unsigned NUM_NOTES = 28;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP,
        DONE
    } state_t;

    // Index 0 is unused; codes 0 and 8..15 are rests.
    localparam int unsigned NOTE_FREQ [8] = '{0, 262, 294, 330, 349, 392, 440, 494};

    function automatic int unsigned half_period(input logic [NOTE_W-1:0] code,
                                                input int unsigned       clk_hz);
        int unsigned h;
        if (code == '0 || code > NOTE_W'(7)) begin
            return 0;
        end
        h = clk_hz / (2 * NOTE_FREQ[code[2:0]]);
        return (h == 0) ? 1 : h;
    endfunction

endpackage

// File: rtl/song_player_tone_gen.sv
// Square-wave tone generator: looks up the half period of the note code
// and toggles the buzzer phase every half period while enabled.
module tone_gen
    import song_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [NOTE_W-1:0] code,
    output logic              buzzer
);

    localparam int unsigned CODES    = 1 << NOTE_W;
    localparam int unsigned MAX_HALF = half_period(NOTE_W'(1), CLK_HZ);
    localparam int unsigned CNT_W    = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;

    logic [CNT_W-1:0] last_lut [CODES];
    logic             tone_lut [CODES];
    logic [CNT_W-1:0] cnt;
    logic             phase;

    // Constant per-code table; the loop unrolls into fixed values.
    always_comb begin
        for (int unsigned i = 0; i < CODES; i++) begin
            tone_lut[i] = (half_period(NOTE_W'(i), CLK_HZ) != 0);
            last_lut[i] = tone_lut[i] ? CNT_W'(half_period(NOTE_W'(i), CLK_HZ) - 1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en && tone_lut[code]) begin
            if (cnt == last_lut[code]) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign buzzer = phase & en;

endmodule

// File: rtl/song_player.sv
// Song player: snapshots a packed song, steps through its notes at a fixed
// beat rate with an optional silent gap, and drives a square-wave buzzer.
module song_player
    import song_pkg::*;
#(
    parameter int unsigned NUM_NOTES  = song_pkg::NUM_NOTES,
    parameter int unsigned NOTE_W     = song_pkg::NOTE_W,
    parameter int unsigned BEAT_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 2_500_000,
    parameter int unsigned CLK_HZ     = 100_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_NOTES*NOTE_W-1:0] song_packed,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        stop,
    output logic                        buzzer,
    output logic [NOTE_W-1:0]           note,
    output logic [4:0]                  note_idx,
    output logic                        playing,
    output logic                        done
);

    localparam int unsigned BEAT_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam int unsigned GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [4:0]        LAST_IDX  = 5'(NUM_NOTES - 1);

    state_t                      state;
    logic [BEAT_W-1:0]           beat_cnt;
    logic [GAP_W-1:0]            gap_cnt;
    logic [NUM_NOTES*NOTE_W-1:0] snap;
    logic [NOTE_W-1:0]           notes [NUM_NOTES];
    logic [4:0]                  next_idx;
    logic                        beat_end, gap_end, advance, is_last;
    logic                        enter_play, tone_en, tone_clr;

    // The tone counter must clear on the same edge that enters PLAY, so
    // the transition conditions are decoded here rather than inside the FSM.
    always_comb begin
        for (int unsigned i = 0; i < NUM_NOTES; i++) begin
            notes[i] = snap[i*NOTE_W +: NOTE_W];
        end
        next_idx   = note_idx + 5'd1;
        beat_end   = (beat_cnt == BEAT_LAST);
        gap_end    = (gap_cnt == GAP_LAST);
        advance    = !pause && ((state == PLAY && beat_end && GAP_TICKS == 0) ||
                                (state == GAP && gap_end));
        is_last    = (note_idx >= LAST_IDX);
        enter_play = !stop && ((start && (state == IDLE || state == DONE)) ||
                               (advance && !is_last));
        tone_en    = (state == PLAY) && !pause;
        tone_clr   = stop || enter_play;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            snap     <= '0;
            note     <= '0;
            note_idx <= '0;
            playing  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                beat_cnt <= '0;
                gap_cnt  <= '0;
                note     <= '0;
                note_idx <= '0;
                playing  <= 1'b0;
            end else if (advance) begin
                beat_cnt <= '0;
                gap_cnt  <= '0;
                if (is_last) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    playing <= 1'b0;
                    note    <= '0;
                end else begin
                    state    <= PLAY;
                    note_idx <= next_idx;
                    note     <= notes[next_idx];
                end
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            snap     <= song_packed;
                            note_idx <= '0;
                            beat_cnt <= '0;
                            gap_cnt  <= '0;
                            note     <= song_packed[NOTE_W-1:0];
                            playing  <= 1'b1;
                            state    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (!pause) begin
                            if (!beat_end) begin
                                beat_cnt <= beat_cnt + 1'b1;
                            end else begin
                                beat_cnt <= '0;
                                gap_cnt  <= '0;
                                note     <= '0;
                                state    <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        if (!pause) begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    tone_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tone (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tone_en),
        .clr   (tone_clr),
        .code  (note),
        .buzzer(buzzer)
    );

endmodule
